// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection phase sequencer.
// Lamp bit positions index the 3-bit per-phase lamp vector built by lamp_sel.
package traffic_pkg;

  typedef enum logic [1:0] {
    ALLRED = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    FLASH  = 2'd3
  } state_t;

  localparam int LAMP_RED    = 0;
  localparam int LAMP_YELLOW = 1;
  localparam int LAMP_GREEN  = 2;

  // Board defaults in 100 ms ticks
  localparam int DEF_GREEN_MIN = 100;
  localparam int DEF_GREEN_EXT = 30;
  localparam int DEF_GREEN_MAX = 450;
  localparam int DEF_YELLOW    = 40;
  localparam int DEF_ALLRED    = 20;

  function automatic logic [2:0] lamp_sel(input state_t s, input logic is_cur, input logic fl_on);
    logic [2:0] l;
    l = '0;
    case (s)
      FLASH:  l[LAMP_YELLOW] = fl_on;
      GREEN:  if (is_cur) l[LAMP_GREEN] = 1'b1; else l[LAMP_RED] = 1'b1;
      YELLOW: if (is_cur) l[LAMP_YELLOW] = 1'b1; else l[LAMP_RED] = 1'b1;
      default: l[LAMP_RED] = 1'b1;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Request inputs, duration config and lamp outputs of the phase sequencer.
// master = board side (sensors/buttons/config), slave = controller.
interface phase_sequencer_if #(
  parameter int NUM_PHASES = 4,
  parameter int TW         = 12
);
  localparam int PW = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1;

  logic                  en;
  logic [NUM_PHASES-1:0] veh_req;
  logic [NUM_PHASES-1:0] ped_req;
  logic [TW-1:0]         green_min;
  logic [TW-1:0]         green_ext;
  logic [TW-1:0]         green_max;
  logic [TW-1:0]         yellow_t;
  logic [TW-1:0]         allred_t;
  logic [NUM_PHASES-1:0] green;
  logic [NUM_PHASES-1:0] yellow;
  logic [NUM_PHASES-1:0] red;
  logic [NUM_PHASES-1:0] ped_walk;
  logic [NUM_PHASES-1:0] ped_wait;
  logic [PW-1:0]         cur_phase;

  modport master (
    output en, veh_req, ped_req, green_min, green_ext, green_max, yellow_t, allred_t,
    input  green, yellow, red, ped_walk, ped_wait, cur_phase
  );

  modport slave (
    input  en, veh_req, ped_req, green_min, green_ext, green_max, yellow_t, allred_t,
    output green, yellow, red, ped_walk, ped_wait, cur_phase
  );
endinterface

// File: rtl/tick_prescaler.sv
// Free-running divider: one-cycle tick enable every TICK_DIV clocks.
// First tick is seen on the TICK_DIV-th edge after reset release.
module tick_prescaler #(
  parameter int TICK_DIV = 1000
) (
  input  logic CLK,
  input  logic reset_n,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n)            div_cnt <= '0;
    else if (div_cnt == LAST) div_cnt <= '0;
    else                      div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == LAST);
endmodule

// File: rtl/phase_sequencer.sv
// N-phase signal controller with gap extension, ped latching and flashing-yellow fallback.
// Lamps are registered, changing on the edge that consumes the deciding tick; SEQ_SKIP_EN selects demand-driven skipping.
module phase_sequencer
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES  = 4,
  parameter int TICK_DIV    = 1000,
  parameter int TW          = 12,
  parameter int FLASH_TICKS = 5
) (
  input logic              CLK,
  input logic              reset_n,
  phase_sequencer_if.slave bus
);
  localparam int PW = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1;
  typedef logic [NUM_PHASES-1:0] vec_t;

  logic tick;
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .CLK     (CLK),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // Two-flop synchronisers; en resets high so a fresh reset starts in ALLRED, not FLASH
  logic en_s1, en_s;
  vec_t veh_s1, veh_s, ped_s1, ped_s, ped_q, ped_rise;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      en_s1  <= 1'b1;
      en_s   <= 1'b1;
      veh_s1 <= '0;
      veh_s  <= '0;
      ped_s1 <= '0;
      ped_s  <= '0;
      ped_q  <= '0;
    end else begin
      en_s1  <= bus.en;
      en_s   <= en_s1;
      veh_s1 <= bus.veh_req;
      veh_s  <= veh_s1;
      ped_s1 <= bus.ped_req;
      ped_s  <= ped_s1;
      ped_q  <= ped_s;
    end
  end

  assign ped_rise = ped_s & ~ped_q;

  function automatic logic [TW-1:0] at_least_one(input logic [TW-1:0] v);
    return (v == '0) ? TW'(1) : v;
  endfunction

  logic [TW-1:0] gmin_e, gext_e, gmax_raw, gmax_e, yel_e, ar_e;
  assign gmin_e   = at_least_one(bus.green_min);
  assign gext_e   = at_least_one(bus.green_ext);
  assign gmax_raw = at_least_one(bus.green_max);
  assign gmax_e   = (gmax_raw < gmin_e) ? gmin_e : gmax_raw;
  assign yel_e    = at_least_one(bus.yellow_t);
  assign ar_e     = at_least_one(bus.allred_t);

  state_t        state, state_d;
  logic [TW-1:0] cnt, cnt_d, gap, gap_d, cnt_inc, gap_inc;
  logic [PW-1:0] cur_phase, cur_d, next_phase, next_d, pick;
  vec_t          walk_q, walk_d, wait_q, wait_d;
  vec_t          green_q, green_d, yellow_q, yellow_d, red_q, red_d;
  logic          flash_on, flash_on_d, enter, exit_green;
  logic [2:0]    lamp;

`ifdef SEQ_SKIP_EN
  vec_t demand;
  logic other_demand;
  int   idx;
  assign demand = veh_s | wait_q;
`endif

  // Successor phase; with skipping, scan downwards so the nearest demanding phase wins
  always_comb begin
    pick = (cur_phase == PW'(NUM_PHASES - 1)) ? '0 : cur_phase + 1'b1;
`ifdef SEQ_SKIP_EN
    other_demand = 1'b0;
    idx          = 0;
    for (int k = NUM_PHASES - 1; k >= 1; k--) begin
      idx = (int'(cur_phase) + k) % NUM_PHASES;
      if (demand[idx]) begin
        pick         = PW'(idx);
        other_demand = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    gap_d      = gap;
    cur_d      = cur_phase;
    next_d     = next_phase;
    walk_d     = walk_q;
    wait_d     = wait_q | ped_rise;
    flash_on_d = flash_on;
    enter      = 1'b0;
    exit_green = 1'b0;
    lamp       = '0;
    green_d    = '0;
    yellow_d   = '0;
    red_d      = '0;
    cnt_inc    = (cnt == '1) ? cnt : cnt + 1'b1;
    gap_inc    = veh_s[cur_phase] ? '0 : ((gap == '1) ? gap : gap + 1'b1);

    if (!en_s) begin
      if (state != FLASH) begin
        state_d    = FLASH;
        enter      = 1'b1;
        flash_on_d = 1'b1;
        walk_d     = '0;
      end else if (tick) begin
        if (cnt_inc >= TW'(FLASH_TICKS)) begin
          cnt_d      = '0;
          flash_on_d = ~flash_on;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    end else begin
      case (state)
        FLASH: begin
          state_d = ALLRED;
          next_d  = '0;
          enter   = 1'b1;
        end
        ALLRED: if (tick) begin
          if (cnt_inc >= ar_e) begin
            state_d = GREEN;
            cur_d   = next_phase;
            enter   = 1'b1;
            walk_d  = '0;
            // A press landing on this very cycle is serviced by this green too
            if (wait_d[next_phase]) begin
              walk_d[next_phase] = 1'b1;
              wait_d[next_phase] = 1'b0;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        GREEN: if (tick) begin
          gap_d = gap_inc;
          if (cnt_inc >= gmin_e) walk_d = '0;
          exit_green = ((cnt_inc >= gmin_e) && (gap_inc >= gext_e)) || (cnt_inc >= gmax_e);
`ifdef SEQ_SKIP_EN
          exit_green = exit_green && other_demand;
`endif
          if (exit_green) begin
            state_d = YELLOW;
            next_d  = pick;
            enter   = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        YELLOW: if (tick) begin
          if (cnt_inc >= yel_e) begin
            state_d = ALLRED;
            enter   = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = ALLRED;
      endcase
    end

    if (enter) begin
      cnt_d = '0;
      gap_d = '0;
    end

    for (int i = 0; i < NUM_PHASES; i++) begin
      lamp        = lamp_sel(state_d, cur_d == PW'(i), flash_on_d);
      green_d[i]  = lamp[LAMP_GREEN];
      yellow_d[i] = lamp[LAMP_YELLOW];
      red_d[i]    = lamp[LAMP_RED];
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ALLRED;
      cnt        <= '0;
      gap        <= '0;
      cur_phase  <= '0;
      next_phase <= '0;
      walk_q     <= '0;
      wait_q     <= '0;
      flash_on   <= 1'b0;
      green_q    <= '0;
      yellow_q   <= '0;
      red_q      <= '1;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      gap        <= gap_d;
      cur_phase  <= cur_d;
      next_phase <= next_d;
      walk_q     <= walk_d;
      wait_q     <= wait_d;
      flash_on   <= flash_on_d;
      green_q    <= green_d;
      yellow_q   <= yellow_d;
      red_q      <= red_d;
    end
  end

  assign bus.green     = green_q;
  assign bus.yellow    = yellow_q;
  assign bus.red       = red_q;
  assign bus.ped_walk  = walk_q;
  assign bus.ped_wait  = wait_q;
  assign bus.cur_phase = cur_phase;
endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: expected lamp segments (value + length in cycles) are queued
// per scenario and retired as the lamp outputs change.
module tb_phase_sequencer;
  localparam int NP = 4;
  localparam int TD = 4;
  localparam int TW = 12;

  logic CLK     = 1'b0;
  logic reset_n = 1'b0;
  always #5 CLK = ~CLK;

  phase_sequencer_if #(.NUM_PHASES(NP), .TW(TW)) bus ();

  phase_sequencer #(
    .NUM_PHASES  (NP),
    .TICK_DIV    (TD),
    .TW          (TW),
    .FLASH_TICKS (5)
  ) dut (
    .CLK     (CLK),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // dur > 0: exact length in cycles; 0: any length; < 0: value check only, no wait
  typedef struct {
    string      name;
    logic [3:0] g, y, r, w;
    int         dur;
  } seg_t;

  seg_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [3:0] onehot(input int p);
    logic [3:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  task automatic push(input string name, input logic [3:0] g, input logic [3:0] y,
                      input logic [3:0] r, input logic [3:0] w, input int dur);
    seg_t s;
    s.name = name; s.g = g; s.y = y; s.r = r; s.w = w; s.dur = dur;
    exp_q.push_back(s);
  endtask

  task automatic push_green(input int p, input int ticks, input logic [3:0] w);
    push($sformatf("green%0d", p), onehot(p), 4'b0000, ~onehot(p), w, (ticks < 0) ? -1 : ticks * TD);
  endtask

  task automatic push_yellow(input int p, input int ticks);
    push($sformatf("yellow%0d", p), 4'b0000, onehot(p), ~onehot(p), 4'b0000, ticks * TD);
  endtask

  task automatic push_allred(input int ticks);
    push("allred", 4'b0000, 4'b0000, 4'b1111, 4'b0000, ticks * TD);
  endtask

  task automatic push_flash(input logic on, input int ticks);
    push(on ? "flash_on" : "flash_off", 4'b0000, {4{on}}, 4'b0000, 4'b0000, (ticks < 0) ? -1 : ticks * TD);
  endtask

  // Called at a negedge; retires queued segments as the lamp vector changes
  task automatic run_monitor(input int budget);
    logic [15:0] cur, now;
    int run, cyc;
    seg_t e;
    cur = {bus.green, bus.yellow, bus.red, bus.ped_walk};
    run = 1;
    cyc = 0;
    while (exp_q.size() > 0) begin
      if (exp_q[0].dur < 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (cur !== {e.g, e.y, e.r, e.w})
          $display("FAIL seg_%s: got g=%b y=%b r=%b w=%b, expected g=%b y=%b r=%b w=%b",
                   e.name, cur[15:12], cur[11:8], cur[7:4], cur[3:0], e.g, e.y, e.r, e.w);
        else n_pass++;
        continue;
      end
      @(negedge CLK);
      cyc++;
      if (cyc > budget) begin
        n_checks++;
        $display("FAIL monitor_timeout: %0d segments still pending, expected 0", exp_q.size());
        exp_q.delete();
        break;
      end
      now = {bus.green, bus.yellow, bus.red, bus.ped_walk};
      if (now !== cur) begin
        e = exp_q.pop_front();
        n_checks++;
        if (cur !== {e.g, e.y, e.r, e.w} || (e.dur != 0 && run != e.dur))
          $display("FAIL seg_%s: got g=%b y=%b r=%b w=%b len=%0d, expected g=%b y=%b r=%b w=%b len=%0d",
                   e.name, cur[15:12], cur[11:8], cur[7:4], cur[3:0], run, e.g, e.y, e.r, e.w, e.dur);
        else n_pass++;
        cur = now;
        run = 1;
      end else begin
        run++;
      end
    end
  endtask

  task automatic do_reset(input logic [3:0] veh);
    @(negedge CLK);
    reset_n     = 1'b0;
    bus.en      = 1'b1;
    bus.veh_req = veh;
    bus.ped_req = '0;
    repeat (2) @(negedge CLK);
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if ({bus.green, bus.yellow, bus.red, bus.ped_walk, bus.ped_wait} !== 20'h00F00)
      $display("FAIL reset_lamps: got g=%b y=%b r=%b walk=%b wait=%b, expected red=1111 rest 0",
               bus.green, bus.yellow, bus.red, bus.ped_walk, bus.ped_wait);
    else n_pass++;
    n_checks++;
    if (bus.cur_phase !== 2'd0) $display("FAIL reset_phase: got %0d, expected 0", bus.cur_phase);
    else n_pass++;
  endtask

  task automatic test_round_robin;
    do_reset(4'b0000);
    push_allred(1);
    for (int p = 0; p < NP; p++) begin
      push_green(p, 3, 4'b0000);
      push_yellow(p, 2);
      push_allred(1);
    end
    push_green(0, -1, 4'b0000);
    run_monitor(600);
    n_checks++;
    if (bus.cur_phase !== 2'd0) $display("FAIL rr_wrap_phase: got %0d, expected 0", bus.cur_phase);
    else n_pass++;
  endtask

  task automatic test_max_out;
    do_reset(4'b1001);
    push_allred(1);
    push_green(0, 8, 4'b0000);
    push_yellow(0, 2);
    push_allred(1);
`ifdef SEQ_SKIP_EN
    push_green(3, -1, 4'b0000);
`else
    push_green(1, -1, 4'b0000);
`endif
    run_monitor(300);
  endtask

  task automatic test_ped;
    do_reset(4'b0000);
    push_allred(1);
    push_green(0, 3, 4'b0000); push_yellow(0, 2); push_allred(1);
    push_green(1, 3, 4'b0000); push_yellow(1, 2); push_allred(1);
    push_green(2, 3, 4'b0100); push_yellow(2, 2); push_allred(1);
    push_green(3, -1, 4'b0000);
    fork
      run_monitor(400);
      begin
        int t;
        t = 0;
        while (bus.green !== 4'b0001 && t < 50) begin @(negedge CLK); t++; end
        @(negedge CLK); bus.ped_req = 4'b0100;
        @(negedge CLK); bus.ped_req = 4'b0000;
        @(negedge CLK);
        n_checks++;
        if (bus.ped_wait !== 4'b0000) $display("FAIL ped_wait_early: got %b, expected 0000", bus.ped_wait);
        else n_pass++;
        @(negedge CLK);
        n_checks++;
        if (bus.ped_wait !== 4'b0100) $display("FAIL ped_wait_set: got %b, expected 0100", bus.ped_wait);
        else n_pass++;
        t = 0;
        while (bus.green !== 4'b0100 && t < 200) begin @(negedge CLK); t++; end
        n_checks++;
        if (bus.ped_wait !== 4'b0000 || bus.ped_walk !== 4'b0100)
          $display("FAIL ped_service: got wait=%b walk=%b green=%b, expected wait=0000 walk=0100 green=0100",
                   bus.ped_wait, bus.ped_walk, bus.green);
        else n_pass++;
      end
    join
  endtask

  task automatic test_skip;
    do_reset(4'b1000);
    push_allred(1);
    push_green(0, 3, 4'b0000);
    push_yellow(0, 2);
    push_allred(1);
    push_green(3, -1, 4'b0000);
    run_monitor(300);
    n_checks++;
    if (bus.cur_phase !== 2'd3) $display("FAIL skip_phase: got %0d, expected 3", bus.cur_phase);
    else n_pass++;
    repeat (80) @(negedge CLK);
    n_checks++;
    if (bus.green !== 4'b1000) $display("FAIL skip_rest_demand: got green=%b, expected 1000", bus.green);
    else n_pass++;
    bus.veh_req = 4'b0000;
    repeat (80) @(negedge CLK);
    n_checks++;
    if (bus.green !== 4'b1000 || bus.yellow !== 4'b0000)
      $display("FAIL skip_rest_idle: got green=%b yellow=%b, expected 1000/0000", bus.green, bus.yellow);
    else n_pass++;
  endtask

  task automatic test_flash;
    do_reset(4'b0000);
    push_allred(1);
    push_green(0, -1, 4'b0000);
    run_monitor(100);
    @(negedge CLK); bus.ped_req = 4'b1000;
    @(negedge CLK); bus.ped_req = 4'b0000;
    repeat (2) @(negedge CLK);
    bus.en = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if (bus.green !== 4'b0001) $display("FAIL flash_sync_hold: got green=%b, expected 0001", bus.green);
    else n_pass++;
    @(negedge CLK);
    n_checks++;
    if ({bus.green, bus.yellow, bus.red, bus.ped_walk, bus.ped_wait} !== 20'h0F008)
      $display("FAIL flash_entry: got g=%b y=%b r=%b walk=%b wait=%b, expected 0000 1111 0000 0000 1000",
               bus.green, bus.yellow, bus.red, bus.ped_walk, bus.ped_wait);
    else n_pass++;
    push_flash(1'b1, 0);
    push_flash(1'b0, 5);
    push_flash(1'b1, 5);
    push_flash(1'b0, -1);
    run_monitor(200);
    bus.en = 1'b1;
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({bus.green, bus.yellow, bus.red} !== 12'h00F)
      $display("FAIL flash_exit: got g=%b y=%b r=%b, expected 0000 0000 1111", bus.green, bus.yellow, bus.red);
    else n_pass++;
    push_allred(0);
    push_green(0, -1, 4'b0000);
    run_monitor(100);
    n_checks++;
    if (bus.cur_phase !== 2'd0) $display("FAIL flash_restart_phase: got %0d, expected 0", bus.cur_phase);
    else n_pass++;
  endtask

  task automatic test_async_reset;
    int t;
    do_reset(4'b0000);
    push_allred(1);
    push_green(0, -1, 4'b0000);
    run_monitor(100);
    @(negedge CLK); bus.ped_req = 4'b0010;
    @(negedge CLK); bus.ped_req = 4'b0000;
    t = 0;
    while (bus.yellow !== 4'b0001 && t < 100) begin @(negedge CLK); t++; end
    n_checks++;
    if (bus.ped_wait !== 4'b0010 || bus.yellow !== 4'b0001)
      $display("FAIL arst_setup: got wait=%b yellow=%b, expected 0010/0001", bus.ped_wait, bus.yellow);
    else n_pass++;
    @(negedge CLK);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.green, bus.yellow, bus.red, bus.ped_walk, bus.ped_wait} !== 20'h00F00)
      $display("FAIL arst_immediate: got g=%b y=%b r=%b walk=%b wait=%b, expected red=1111 rest 0",
               bus.green, bus.yellow, bus.red, bus.ped_walk, bus.ped_wait);
    else n_pass++;
    repeat (2) @(negedge CLK);
    reset_n = 1'b1;
    push_allred(1);
    push_green(0, -1, 4'b0000);
    run_monitor(100);
    n_checks++;
    if (bus.cur_phase !== 2'd0) $display("FAIL arst_restart_phase: got %0d, expected 0", bus.cur_phase);
    else n_pass++;
  endtask

  initial begin
    bus.en        = 1'b1;
    bus.veh_req   = '0;
    bus.ped_req   = '0;
    bus.green_min = 12'd3;
    bus.green_ext = 12'd2;
    bus.green_max = 12'd8;
    bus.yellow_t  = 12'd2;
    bus.allred_t  = 12'd1;
    test_reset;
`ifdef SEQ_SKIP_EN
    test_skip;
`else
    test_round_robin;
    test_ped;
`endif
    test_max_out;
    test_flash;
    test_async_reset;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
